// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared unit/sub-op encodings and FSM state type for alu_seq
package alu_seq_pkg;

   typedef enum logic [1:0] {ARITH = 2'b00, LOGIC = 2'b01, SHL = 2'b10, SHR = 2'b11} unit_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_INC = 2'b10;
   localparam logic [1:0] OP_DEC = 2'b11;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOT = 2'b11;

   localparam logic [1:0] SH_LOG = 2'b00;
   localparam logic [1:0] SH_ARI = 2'b01;
   localparam logic [1:0] SH_ROT = 2'b10;
   localparam logic [1:0] SH_RSV = 2'b11;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

endpackage

// File: rtl/alu_seq_comb.sv
// rtl/alu_seq_comb.sv - single-cycle arith/logic/one-bit-shift unit; ALU_ROTATE_EN adds rotate
module alu_seq_comb #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [3:0]       s,
   output logic [WIDTH-1:0] d,
   output logic             z,
   output logic             n,
   output logic             cout,
   output logic             v
);
   import alu_seq_pkg::*;

   localparam int M = WIDTH - 1;

   logic [WIDTH-1:0] addend;
   logic             carry;
   logic [WIDTH:0]   sum;

   // Every arith sub-op is one adder: a + addend + carry.
   always_comb begin
      addend = b;
      carry  = cin;
      case (s[1:0])
         OP_SUB:  begin addend = ~b;  carry = 1'b1; end
         OP_INC:  begin addend = '0;  carry = 1'b1; end
         OP_DEC:  begin addend = '1;  carry = 1'b0; end
         default: ;
      endcase
   end

   assign sum = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, carry};

   always_comb begin
      d    = '0;
      cout = 1'b0;
      v    = 1'b0;
      case (unit_t'(s[3:2]))
         ARITH: begin
            d    = sum[M:0];
            cout = sum[WIDTH];
            v    = (a[M] == addend[M]) && (sum[M] != a[M]);
         end
         LOGIC: begin
            case (s[1:0])
               OP_AND:  d = a & b;
               OP_OR:   d = a | b;
               OP_XOR:  d = a ^ b;
               default: d = ~a;
            endcase
         end
         SHL: begin
            case (s[1:0])
               SH_RSV:  d = a;
`ifdef ALU_ROTATE_EN
               SH_ROT:  begin d = {a[M-1:0], a[M]}; cout = a[M]; end
`endif
               default: begin d = {a[M-1:0], 1'b0}; cout = a[M]; end
            endcase
         end
         SHR: begin
            case (s[1:0])
               SH_RSV:  d = a;
               SH_ARI:  begin d = {a[M], a[M:1]}; cout = a[0]; end
`ifdef ALU_ROTATE_EN
               SH_ROT:  begin d = {a[0], a[M:1]}; cout = a[0]; end
`endif
               default: begin d = {1'b0, a[M:1]}; cout = a[0]; end
            endcase
         end
      endcase
      z = (d == '0);
      n = d[M];
   end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked sequential ALU: FSM, shift counter and registered result/flags
module alu_seq #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic [3:0]       S,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] D,
   output logic             Z,
   output logic             N,
   output logic             Cout,
   output logic             V
);
   import alu_seq_pkg::*;

   state_t           state;
   logic [WIDTH-1:0] work;
   logic [3:0]       op;
   logic [SHW-1:0]   cnt;
   logic [SHW-1:0]   k;

   logic [WIDTH-1:0] c_a, c_d;
   logic [3:0]       c_s;
   logic             c_z, c_n, c_cout, c_v;

   assign k = B[SHW-1:0];

   // In IDLE the unit sees the live operands; while shifting it steps the working register.
   assign c_a = (state == IDLE) ? A : work;
   assign c_s = (state == IDLE) ? S : op;

   alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
      .a    (c_a),
      .b    (B),
      .cin  (Cin),
      .s    (c_s),
      .d    (c_d),
      .z    (c_z),
      .n    (c_n),
      .cout (c_cout),
      .v    (c_v)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         D         <= '0;
         Z         <= 1'b0;
         N         <= 1'b0;
         Cout      <= 1'b0;
         V         <= 1'b0;
         work      <= '0;
         op        <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  in_ready <= 1'b0;
                  if (S[3] && k != '0) begin
                     work  <= A;
                     op    <= S;
                     cnt   <= k;
                     state <= SHIFT;
                  end else if (S[3]) begin
                     D         <= A;
                     Z         <= (A == '0);
                     N         <= A[WIDTH-1];
                     Cout      <= 1'b0;
                     V         <= 1'b0;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     D         <= c_d;
                     Z         <= c_z;
                     N         <= c_n;
                     Cout      <= c_cout;
                     V         <= c_v;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end else begin
                  in_ready <= 1'b1;
               end
            end
            SHIFT: begin
               work <= c_d;
               cnt  <= cnt - SHW'(1);
               if (cnt == SHW'(1)) begin
                  D         <= c_d;
                  Z         <= c_z;
                  N         <= c_n;
                  Cout      <= c_cout;
                  V         <= c_v;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 8-bit dataflow ALU: arithmetic, logic and shift units behind a small control FSM, with registered results and flags. Operands enter on a valid/ready input channel and results leave on a valid/ready output channel. Shifts take a variable amount and are iterated one bit per cycle. The block sits between the operand register file and the writeback stage of the datapath.

## Interface
- WIDTH, 8, operand/result width; must be ≥ 2
- SHW, $clog2(WIDTH), width of the shift-amount field taken from B
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand bundle valid
- in_ready  out  1  block can accept a bundle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B; B[SHW-1:0] is the shift amount for shift ops
- Cin  in  1  carry in; used only by ADD
- S  in  4  op select: S[3:2] unit (00 arith, 01 logic, 10 shift left, 11 shift right), S[1:0] sub-op
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- D  out  WIDTH  result
- Z  out  1  D == 0
- N  out  1  D[WIDTH-1]
- Cout  out  1  carry/borrow/shifted-out bit
- V  out  1  signed overflow (arith only, else 0)

## Operation
- Arith S[1:0]: 00 A+B+Cin; 01 A−B (A+~B+1, Cout=1 means no borrow); 10 A+1; 11 A−1. Internal add is WIDTH+1 bits; Cout = bit WIDTH. V = operand signs equal (B inverted for sub) and result sign differs.
- Logic S[1:0]: 00 AND, 01 OR, 10 XOR, 11 NOT A. Cout=0, V=0.
- Shift S[1:0]: 00 logical; 01 arithmetic (right only; left behaves as logical); 10 rotate (see Configuration); 11 reserved, D=A, Cout=0. Amount k = B[SHW-1:0]. Each iteration shifts by 1; Cout = last bit shifted out (rotate: last bit wrapped). If k=0, D=A, Cout=0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. On in_valid, capture the operands. Non-shift op or k=0: compute, register D and flags, go to DONE. Shift with k>0: load the working register with A and the counter with k, go to SHIFT.
  - SHIFT: shift one bit per cycle and decrement the counter. When the counter reaches 1, register the final D/flags and go to DONE.
  - DONE: out_valid=1, with D and flags held stable. On out_ready, go to IDLE.
- Z and N are always derived from the final D, for every op.

## Timing
- Reset values: in_ready=0 during reset and 1 in the first cycle after; out_valid=0, D=0, Z=0, N=0, Cout=0, V=0; state IDLE.
- Accept edge = cycle 0. out_valid rises at cycle 1 for non-shift ops or k=0, and at cycle 1+k for a shift by k. Maximum latency is WIDTH cycles.
- in_ready=0 in SHIFT and DONE. No overlap: peak throughput is one op per 2 cycles.
- out_valid stays high and D/flags stay constant until out_ready is sampled high. out_ready while out_valid=0 is ignored.
- in_valid while in_ready=0 is ignored. Inputs are not required to be held.
- Reset asserted in any state, including mid-SHIFT: the next edge forces IDLE and the reset values, and the pending op is dropped.

## Configuration
- ALU_ROTATE_EN defined: shift sub-op 10 rotates left or right by k.
- ALU_ROTATE_EN undefined: sub-op 10 behaves exactly like sub-op 00 (logical), and no rotate logic is generated.

## Structure
- Package alu_seq_pkg holds:
  - unit encodings ARITH, LOGIC, SHL, SHR
  - sub-op constants
  - the FSM state enum {IDLE, SHIFT, DONE}
- Sub-module alu_seq_comb: purely combinational single-cycle arith/logic/one-bit-shift unit producing D and flags. alu_seq instantiates it and owns the FSM, counter and registers.

## Test plan
- WIDTH=8, A=0xFF, B=0x01, Cin=0, S=0000 → one cycle later out_valid, D=0x00, Z=1, Cout=1, V=0, N=0.
- A=0x7F, B=0x01, S=0001 (SUB) → D=0x7E, Cout=1; then A=0x80, B=0x01 → D=0x7F, V=1, Cout=1.
- A=0x96, B=0x03, S=1101 (arith right) → out_valid at cycle 4, D=0xF2, Cout=1, N=1. in_ready=0 in cycles 1–4.
- A=0x81, B=0x01, S=1010 → with ALU_ROTATE_EN: D=0x03, Cout=1; without it: D=0x02, Cout=1.
- Hold out_ready=0 for 5 cycles after the result → D and flags stable, in_ready=0 throughout; a new in_valid is ignored. out_ready=1 → next cycle in_ready=1.
- Shift left by 7 in progress, rst_n=0 at cycle 3 → next edge out_valid=0, D=0, and the op never completes.
